// File: rtl/ysyx_24100012_alu_issue.sv
// Operand-issue stage: decodes an RV32I packet into ALU operands/keys and buffers them in a 2-entry queue.
// Optional macro YSYX_ALU_ISSUE_STICKY_ILL_EN: after an illegal push, in_ready stays low until reset.
module ysyx_24100012_alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_SEL_W  = 4,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] inst,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] in_a,
    output logic [DATA_WIDTH-1:0] in_b,
    output logic [ALU_SEL_W-1:0]  alu_sel,
    output logic [2:0]            inst_type,
    output logic [4:0]            rd,
    output logic                  illegal
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [ALU_SEL_W-1:0]  sel;
        logic [2:0]            typ;
        logic [4:0]            rd;
        logic                  ill;
    } entry_t;

    entry_t      dec, head, tail;
    logic [1:0]  count, next_count;
    logic        push, pop, next_sticky;
    logic [2:0]  f3;
    logic        is_shift;
    logic [31:0] imm_i, imm_s, imm_u;

    assign f3       = inst[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u    = {inst[31:12], 12'b0};

    always_comb begin
        dec     = '0;
        dec.rd  = inst[11:7];
        case (inst[6:0])
            7'b0110011: begin
                dec.a   = rs1_data;
                dec.b   = is_shift ? {27'b0, rs2_data[4:0]} : rs2_data;
                dec.sel = {inst[30], f3};
                dec.typ = 3'd0;
            end
            7'b0010011: begin
                dec.a   = rs1_data;
                dec.b   = is_shift ? {27'b0, inst[24:20]} : imm_i;
                dec.sel = {(f3 == 3'b101) ? inst[30] : 1'b0, f3};
                dec.typ = 3'd1;
            end
            7'b0000011: begin
                dec.a   = rs1_data;
                dec.b   = imm_i;
                dec.typ = 3'd1;
            end
            7'b1100111: begin
                dec.a   = pc;
                dec.b   = 32'd4;
                dec.typ = 3'd1;
            end
            7'b0100011: begin
                dec.a   = rs1_data;
                dec.b   = imm_s;
                dec.typ = 3'd2;
            end
            7'b1100011: begin
                // Branch compare is reduced to sub/slt/sltu; the EXU interprets the result.
                dec.a   = rs1_data;
                dec.b   = rs2_data;
                dec.typ = 3'd3;
                case (f3)
                    3'b000, 3'b001: dec.sel = 4'b1000;
                    3'b100, 3'b101: dec.sel = 4'b0010;
                    3'b110, 3'b111: dec.sel = 4'b0011;
                    default:        dec.ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec.b   = imm_u;
                dec.typ = 3'd4;
            end
            7'b0010111: begin
                dec.a   = pc;
                dec.b   = imm_u;
                dec.typ = 3'd4;
            end
            7'b1101111: begin
                dec.a   = pc;
                dec.b   = 32'd4;
                dec.typ = 3'd5;
            end
            default: dec.ill = 1'b1;
        endcase
    end

    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        next_count = count;
        if (push && !pop)      next_count = count + 2'd1;
        else if (pop && !push) next_count = count - 2'd1;
    end

`ifdef YSYX_ALU_ISSUE_STICKY_ILL_EN
    logic sticky;
    assign next_sticky = sticky || (push && dec.ill);
    always_ff @(posedge clk) begin
        if (!rst) sticky <= 1'b0;
        else      sticky <= next_sticky;
    end
`else
    assign next_sticky = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= 2'd0;
            head     <= '0;
            tail     <= '0;
            in_ready <= 1'b0;
        end else begin
            count    <= next_count;
            in_ready <= (next_count < 2'd2) && !next_sticky;
            // Head is slot 0; a pop shifts slot 1 forward unless a same-cycle push replaces it.
            if (pop) begin
                head <= push ? dec : tail;
            end else if (push) begin
                if (count == 2'd0) head <= dec;
                else               tail <= dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (count <= 2'(DEPTH));
    end

    assign in_a      = head.a;
    assign in_b      = head.b;
    assign alu_sel   = head.sel;
    assign inst_type = head.typ;
    assign rd        = head.rd;
    assign illegal   = head.ill;
endmodule

// File: tb/tb_ysyx_24100012_alu_issue.sv
// Self-checking bench for ysyx_24100012_alu_issue: directed cases plus randomized traffic vs a queue model.
module tb_ysyx_24100012_alu_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] inst = '0, pc = '0, rs1_data = '0, rs2_data = '0;
    logic [31:0] in_a, in_b;
    logic [3:0]  alu_sel;
    logic [2:0]  inst_type;
    logic [4:0]  rd;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24100012_alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_a(in_a), .in_b(in_b), .alu_sel(alu_sel), .inst_type(inst_type),
        .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic        ill;
    } pkt_t;

    pkt_t q[$];
    logic sticky_m = 1'b0;

    logic [78:0] got_vec;
    assign got_vec = {out_valid, in_ready,
                      out_valid ? {in_a, in_b, alu_sel, inst_type, rd, illegal} : 77'b0};

    function automatic pkt_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        pkt_t   e;
        int     f3;
        logic [31:0] immi, imms;
        e    = '0;
        e.rd = ins[11:7];
        f3   = int'(ins[14:12]);
        immi = 32'($signed(ins[31:20]));
        imms = 32'($signed({ins[31:25], ins[11:7]}));
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.typ = 0; e.sel = {ins[30], ins[14:12]};
                e.b = (f3 == 1 || f3 == 5) ? (r2 % 32) : r2;
            end
            7'h13: begin
                e.a = r1; e.typ = 1;
                e.sel = {(f3 == 5) && ins[30], ins[14:12]};
                e.b = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : immi;
            end
            7'h03: begin e.a = r1; e.b = immi; e.typ = 1; end
            7'h67: begin e.a = p;  e.b = 4;    e.typ = 1; end
            7'h23: begin e.a = r1; e.b = imms; e.typ = 2; end
            7'h63: begin
                e.a = r1; e.b = r2; e.typ = 3;
                if (f3 < 2)       e.sel = 4'd8;
                else if (f3 < 4)  e.ill = 1'b1;
                else if (f3 < 6)  e.sel = 4'd2;
                else              e.sel = 4'd3;
            end
            7'h37: begin e.b = ins & 32'hFFFFF000; e.typ = 4; end
            7'h17: begin e.a = p; e.b = ins & 32'hFFFFF000; e.typ = 4; end
            7'h6F: begin e.a = p; e.b = 4; e.typ = 5; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic exp_ready();
        return (q.size() < 2) && !sticky_m;
    endfunction

    function automatic logic [78:0] exp_vec();
        if (q.size() > 0)
            return {1'b1, exp_ready(), q[0].a, q[0].b, q[0].sel, q[0].typ, q[0].rd, q[0].ill};
        return {1'b0, exp_ready(), 77'b0};
    endfunction

    // Drive one cycle of inputs, advance the model by the handshake rules, then step past the edge.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input logic ordy);
        logic do_push, do_pop;
        pkt_t e;
        in_valid = v; inst = i; pc = p; rs1_data = r1; rs2_data = r2; out_ready = ordy;
        do_push = v && exp_ready();
        do_pop  = (q.size() > 0) && ordy;
        e = ref_decode(i, p, r1, r2);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(e);
`ifdef YSYX_ALU_ISSUE_STICKY_ILL_EN
            if (e.ill) sticky_m = 1'b1;
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; inst = 32'h002081B3; out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        q.delete(); sticky_m = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_hs: got %b exp 00", {out_valid, in_ready});
        end
        n_tests++;
        if ({in_a, in_b, alu_sel, inst_type, rd, illegal} !== 77'b0) begin
            n_fail++; $display("FAIL reset_zero: a=%h b=%h sel=%h exp all zero", in_a, in_b, alu_sel);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: got %b exp 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_decode();
        cycle(1, 32'h002081B3, 32'h100, 5, 7, 1);
        n_tests++;
        if ({out_valid, in_a, in_b, alu_sel, inst_type, rd} !== {1'b1, 32'd5, 32'd7, 4'd0, 3'd0, 5'd3}) begin
            n_fail++; $display("FAIL add: got v=%b a=%h b=%h sel=%h t=%0d rd=%0d", out_valid, in_a, in_b, alu_sel, inst_type, rd);
        end
        cycle(1, 32'h40315093, 32'h104, 32'h80000000, 0, 1);
        n_tests++;
        if ({out_valid, in_a, in_b, alu_sel, inst_type, rd} !== {1'b1, 32'h80000000, 32'd3, 4'b1101, 3'd1, 5'd1}) begin
            n_fail++; $display("FAIL srai: got a=%h b=%h sel=%b t=%0d rd=%0d", in_a, in_b, alu_sel, inst_type, rd);
        end
        cycle(1, 32'h123452B7, 32'h108, 32'hDEAD, 32'hBEEF, 1);
        n_tests++;
        if ({in_a, in_b, alu_sel, inst_type, rd} !== {32'd0, 32'h12345000, 4'd0, 3'd4, 5'd5}) begin
            n_fail++; $display("FAIL lui: got a=%h b=%h sel=%b t=%0d rd=%0d", in_a, in_b, alu_sel, inst_type, rd);
        end
        cycle(1, {7'b0, 5'd2, 5'd1, 3'b110, 5'b0, 7'b1100011}, 32'h10C, 1, 32'hFFFFFFFF, 1);
        n_tests++;
        if ({in_a, in_b, alu_sel, inst_type} !== {32'd1, 32'hFFFFFFFF, 4'b0011, 3'd3}) begin
            n_fail++; $display("FAIL bltu: got a=%h b=%h sel=%b t=%0d", in_a, in_b, alu_sel, inst_type);
        end
        cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (got_vec !== exp_vec()) begin
            n_fail++; $display("FAIL drain_empty: got %h exp %h", got_vec, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        cycle(1, 32'h002081B3, 0, 11, 1, 0);
        n_tests++;
        if ({out_valid, in_ready, in_a} !== {1'b1, 1'b1, 32'd11}) begin
            n_fail++; $display("FAIL bp_first: got v=%b r=%b a=%0d", out_valid, in_ready, in_a);
        end
        cycle(1, 32'h002081B3, 0, 22, 2, 0);
        n_tests++;
        if ({out_valid, in_ready, in_a} !== {1'b1, 1'b0, 32'd11}) begin
            n_fail++; $display("FAIL bp_full: got v=%b r=%b a=%0d exp 1 0 11", out_valid, in_ready, in_a);
        end
        cycle(1, 32'h002081B3, 0, 33, 3, 0);
        n_tests++;
        if ({in_ready, in_a} !== {1'b0, 32'd11}) begin
            n_fail++; $display("FAIL bp_hold: got r=%b a=%0d exp 0 11", in_ready, in_a);
        end
        cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({out_valid, in_ready, in_a, in_b} !== {1'b1, 1'b1, 32'd22, 32'd2}) begin
            n_fail++; $display("FAIL bp_drain1: got v=%b r=%b a=%0d b=%0d exp 1 1 22 2", out_valid, in_ready, in_a, in_b);
        end
        cycle(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_drain2: got v=%b r=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[$] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] ins;
        for (int k = 0; k < 200; k++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, ops.size() - 1)];
`ifdef YSYX_ALU_ISSUE_STICKY_ILL_EN
            if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14] = 1'b1;
`else
            if ($urandom_range(0, 15) == 0) ins[6:0] = 7'h7F;
`endif
            cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom, $urandom_range(0, 2) != 0);
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h exp %h", k, got_vec, exp_vec());
            end
        end
        while (q.size() > 0) cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        cycle(1, 32'h002081B3, 0, 1, 2, 0);
        cycle(1, 32'h002081B3, 0, 3, 4, 0);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL mid_full: got %b exp 10", {out_valid, in_ready});
        end
        rst = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        q.delete(); sticky_m = 1'b0;
        n_tests++;
        if ({out_valid, in_ready, in_a, in_b} !== {2'b00, 64'd0}) begin
            n_fail++; $display("FAIL mid_reset: got v=%b r=%b a=%h b=%h exp all 0", out_valid, in_ready, in_a, in_b);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mid_release: got %b exp 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_illegal();
`ifndef YSYX_ALU_ISSUE_STICKY_ILL_EN
        cycle(1, {17'h0, 3'b010, 5'd9, 7'b1100011}, 0, 1, 2, 1);
        n_tests++;
        if ({out_valid, illegal} !== 2'b11) begin
            n_fail++; $display("FAIL br_ill: got v=%b ill=%b exp 1 1", out_valid, illegal);
        end
`endif
        cycle(1, 32'hFFFFFFFF, 32'h200, 9, 9, 1);
        n_tests++;
        if ({out_valid, illegal, alu_sel, inst_type, in_a, in_b, rd} !== {2'b11, 4'd0, 3'd0, 64'd0, 5'd31}) begin
            n_fail++; $display("FAIL ill_op: got v=%b ill=%b sel=%b t=%0d a=%h b=%h", out_valid, illegal, alu_sel, inst_type, in_a, in_b);
        end
        n_tests++;
        if (got_vec !== exp_vec()) begin
            n_fail++; $display("FAIL ill_ready: got %h exp %h", got_vec, exp_vec());
        end
    endtask

`ifdef YSYX_ALU_ISSUE_STICKY_ILL_EN
    task automatic test_sticky();
        for (int k = 0; k < 4; k++) begin
            cycle(1, 32'h002081B3, 0, k, k, 1);
            n_tests++;
            if ({out_valid, in_ready} !== 2'b00) begin
                n_fail++; $display("FAIL sticky[%0d]: got v=%b r=%b exp 0 0", k, out_valid, in_ready);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        q.delete(); sticky_m = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL sticky_clear: got r=%b exp 1", in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_illegal();
`ifdef YSYX_ALU_ISSUE_STICKY_ILL_EN
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_24100012_alu_issue.md
Name: ysyx_24100012_alu_issue

Overview:
Operand-issue stage that drives the team's ALU. It takes a decoded-fetch packet (instruction word, PC, register-file read data) and turns it into ALU operands in_a/in_b, a 4-bit alu_sel key and a 3-bit inst_type. Results are buffered in a 2-entry queue with valid/ready handshakes on both sides. The block sits between IFU/register-file read and the ALU in the NPC core.

Parameters:
DATA_WIDTH, 32, operand/PC/instruction width (RV32 only; other values unsupported)
ALU_SEL_W, 4, width of alu_sel key, encoded {funct7[5]-class bit, funct3}
DEPTH, 2, queue entries (fixed at 2; the parameter exists only for assertions)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
in_valid  in  1  upstream packet valid
in_ready  out  1  upstream may push; registered, equals (count<2)
inst  in  32  RV32I instruction word
pc  in  32  instruction PC
rs1_data  in  32  register-file value for inst[19:15]
rs2_data  in  32  register-file value for inst[24:20]
out_valid  out  1  head entry valid
out_ready  in  1  ALU/EXU accepts head
in_a  out  32  ALU operand A
in_b  out  32  ALU operand B
alu_sel  out  4  ALU operation key
inst_type  out  3  0=R 1=I 2=S 3=B 4=U 5=J
rd  out  5  destination register inst[11:7]
illegal  out  1  head entry was an unsupported opcode

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low. rst=0 at a rising edge clears count to 0 and zeros all queue entries. out_valid=0, in_ready=0 while rst=0, and in_ready=1 on the first cycle after release. in_a/in_b/alu_sel/inst_type/rd/illegal all read 0 after reset. In-flight entries are discarded.
- Push when in_valid&&in_ready; pop when out_valid&&out_ready. Decode happens combinationally on push, and the decoded result is written into the queue. Latency: a push at edge N gives out_valid=1 from edge N onward (1 cycle).
- Queue: FIFO order. Push+pop in the same cycle at count=1 keeps count=1, with the new entry at the head next cycle. No push is possible at count=2. Pop at count=0 is ignored. Outputs hold stable while out_valid&&!out_ready.
- Decode by opcode inst[6:0]:
  - 0110011 OP: a=rs1, b=rs2, sel={inst[30],f3}, type 0. For f3=001/101, b={27'b0,rs2[4:0]}.
  - 0010011 OP-IMM: a=rs1, b=sext(immI), type 1. sel={f3==101?inst[30]:0, f3}. For f3=001/101, b={27'b0,inst[24:20]}.
  - 0000011 LOAD / 1100111 JALR: type 1. LOAD: a=rs1, b=sext(immI), sel 0000. JALR: a=pc, b=4, sel 0000 (link value).
  - 0100011 STORE: a=rs1, b=sext(immS), sel 0000, type 2.
  - 1100011 BRANCH: a=rs1, b=rs2, type 3. f3 000/001 -> 1000 (sub). f3 100/101 -> 0010 (slt). f3 110/111 -> 0011 (sltu). f3 010/011 -> illegal.
  - 0110111 LUI: a=0, b={inst[31:12],12'b0}, sel 0000, type 4. 0010111 AUIPC: a=pc, same b, type 4.
  - 1101111 JAL: a=pc, b=4, sel 0000, type 5.
  - Any other opcode: illegal=1, a=b=0, sel 0000, type 0. The entry is still queued and popped normally.
- rd = inst[11:7] for all types. For S and B types the rd field is passed through unused.

Optional Feature:
YSYX_ALU_ISSUE_STICKY_ILL_EN
- Defined: once an illegal entry is pushed, in_ready is forced to 0 until reset. Entries already queued still drain.
- Undefined: illegal entries flow like any other; in_ready depends only on count.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 -> no push, out_valid=0, all outputs 0. After release, in_ready=1.
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, in_a=5, in_b=7, alu_sel=0000, inst_type=0, rd=3.
- srai x1,x2,3 (0x40315093), rs1=0x80000000 -> alu_sel=1101, in_b=3, inst_type=1. lui x5,0x12345 (0x123452B7) -> in_a=0, in_b=0x12345000, type 4.
- bltu (f3=110), rs1=1, rs2=0xFFFFFFFF -> alu_sel=0011, type 3. inst=0xFFFFFFFF -> illegal=1, sel 0000.
- Backpressure: out_ready=0, push 3 back-to-back packets -> 2 accepted, in_ready=0 after the 2nd. Then out_ready=1 -> packets drain in order, one per cycle.
- Reset mid-operation with count=2 -> next cycle out_valid=0 and count=0. With YSYX_ALU_ISSUE_STICKY_ILL_EN, push 0xFFFFFFFF -> in_ready stays 0 until rst=0.
